// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - write/read handshake and status bundle for sync_fifo_prog
//
// Purpose: groups the FIFO data path and status flags into one port.
//   master modport: drives din/wr_en/rd_en, observes data and flags (the FIFO user)
//   slave modport : the FIFO itself
// Signals:
//   din       WIDTH              write data
//   wr_en     1                  write request
//   rd_en     1                  read request (FWFT: acknowledge of head word)
//   dout      WIDTH              read data
//   valid     1                  dout holds a newly read word
//   full/empty/almost_full/almost_empty  status flags
//   count     $clog2(DEPTH)+1    current fill level
//   overflow/underflow           sticky error flags
interface sync_fifo_prog_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds and optional FWFT read
//
// Purpose: DEPTH-word synchronous FIFO. Status flags decode from the registered
// fill count only, so a request is judged against the state at the start of
// its cycle (a write at full is refused even if a read frees a slot that cycle).
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  sync_fifo_prog_if.slave (din, wr_en, rd_en, dout, valid, flags, count)
// Parameters: WIDTH, DEPTH (power of two, >= 4), FWFT (0 registered read,
// 1 first-word-fall-through), AF_THRESH, AE_THRESH.
module sync_fifo_prog #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_prog_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full, empty;
  logic             wr_accept, rd_accept;
  logic [WIDTH-1:0] head;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign wr_accept = bus.wr_en && !full;
  assign rd_accept = bus.rd_en && !empty;
  assign head      = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q  | (bus.wr_en && full);
    underflow_d = underflow_q | (bus.rd_en && empty);

    // Pointers are exactly AW bits wide, so the increment wraps DEPTH-1 -> 0.
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = head;
      valid_d  = 1'b1;
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem[wr_ptr_q] <= bus.din;
  end

  // FWFT presents the head word directly; the registered path is used otherwise.
  assign bus.dout         = (FWFT != 0) ? (empty ? '0 : head) : dout_q;
  assign bus.valid        = (FWFT != 0) ? !empty : valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - scoreboard bench for sync_fifo_prog in registered and FWFT modes
module tb_sync_fifo_prog;
  localparam int W = 32;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.WIDTH(W), .DEPTH(D)) b0 ();
  sync_fifo_prog_if #(.WIDTH(W), .DEPTH(D)) b1 ();

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int mc0, mc1;
  bit movf0, mudf0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags0();
    check("count0", 64'(b0.count), 64'(mc0));
    check("flags0", {58'd0, b0.full, b0.empty, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow},
          {58'd0, mc0 == D, mc0 == 0, mc0 >= D - 2, mc0 <= 2, movf0, mudf0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b0.wr_en = 1'b0; b0.rd_en = 1'b0;
    b1.wr_en = 1'b0; b1.rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    mc0 = 0; mc1 = 0; movf0 = 0; mudf0 = 0;
  endtask

  // Registered-read DUT: expected words queue on accepted writes, are popped when valid pulses.
  task automatic step0(bit w, bit r, logic [W-1:0] d);
    bit aw, ar;
    logic [W-1:0] exp;
    aw = w && (mc0 < D);
    ar = r && (mc0 > 0);
    if (w && mc0 == D) movf0 = 1;
    if (r && mc0 == 0) mudf0 = 1;
    b0.wr_en = w; b0.rd_en = r; b0.din = d;
    @(posedge clk); #1;
    b0.wr_en = 1'b0; b0.rd_en = 1'b0;
    if (aw) q0.push_back(d);
    mc0 = mc0 + int'(aw) - int'(ar);
    check("valid0", 64'(b0.valid), 64'(ar));
    if (ar) begin
      exp = q0.pop_front();
      check("dout0", 64'(b0.dout), 64'(exp));
    end
    check_flags0();
  endtask

  // FWFT DUT: the head of the queue must be on dout whenever the FIFO is non-empty.
  task automatic step1(bit w, bit r, logic [W-1:0] d);
    bit aw, ar;
    aw = w && (mc1 < D);
    ar = r && (mc1 > 0);
    b1.wr_en = w; b1.rd_en = r; b1.din = d;
    @(posedge clk); #1;
    b1.wr_en = 1'b0; b1.rd_en = 1'b0;
    if (ar) void'(q1.pop_front());
    if (aw) q1.push_back(d);
    mc1 = mc1 + int'(aw) - int'(ar);
    check("count1", 64'(b1.count), 64'(mc1));
    check("empty1", 64'(b1.empty), 64'(mc1 == 0));
    check("valid1", 64'(b1.valid), 64'(mc1 > 0));
    if (mc1 > 0) check("dout1", 64'(b1.dout), 64'(q1[0]));
  endtask

  initial begin
    rst = 1'b1;
    b0.din = '0; b0.wr_en = 1'b0; b0.rd_en = 1'b0;
    b1.din = '0; b1.wr_en = 1'b0; b1.rd_en = 1'b0;

    // Reset then idle
    do_reset();
    step0(0, 0, '0);
    check("rst_dout0", 64'(b0.dout), 64'd0);
    check("rst_valid0", 64'(b0.valid), 64'd0);

    // Write 0..7 then read 8; dout holds last word afterwards
    for (int i = 0; i < 8; i++) step0(1, 0, W'(i));
    for (int i = 0; i < 8; i++) step0(0, 1, '0);
    step0(0, 0, '0);
    check("hold_dout0", 64'(b0.dout), 64'd7);

    // Read while empty: underflow sets, overflow stays clear, no valid
    step0(0, 1, '0);
    step0(0, 0, '0);
    check("udf_sticky", 64'(b0.underflow), 64'd1);

    // Fill to full, overflow attempt, simultaneous req at full, drain
    do_reset();
    for (int i = 0; i < 16; i++) step0(1, 0, W'(i));
    step0(1, 0, 32'hDEAD);
    step0(1, 1, 32'hBEEF);
    step0(1, 0, 32'h0000_0F00);
    for (int i = 0; i < 17; i++) step0(0, 1, '0);
    // Simultaneous at empty: write accepted, read refused
    step0(1, 1, 32'h55);
    step0(0, 1, '0);

    // Preload 5 then 40 cycles of concurrent read/write
    do_reset();
    for (int i = 0; i < 5; i++) step0(1, 0, W'(100 + i));
    for (int i = 0; i < 40; i++) step0(1, 1, W'(105 + i));
    for (int i = 0; i < 5; i++) step0(0, 1, '0);

    // Reset mid-operation discards stored words
    for (int i = 0; i < 3; i++) step0(1, 0, W'(200 + i));
    do_reset();
    check_flags0();
    step0(1, 0, 32'h77);
    step0(0, 1, '0);
    check("scoreboard0_empty", 64'(q0.size()), 64'd0);

    // FWFT mode
    do_reset();
    step1(1, 0, 32'hA5);
    check("fwft_a5", 64'(b1.dout), 64'hA5);
    step1(0, 1, '0);
    for (int i = 0; i < 3; i++) step1(1, 0, W'(i + 1));
    step1(0, 1, '0);
    for (int i = 0; i < 2; i++) step1(1, 0, W'(i + 10));
    do_reset();
    check("fwft_rst_count", 64'(b1.count), 64'd0);
    step1(1, 0, 32'h11);
    step1(1, 1, 32'h12);
    step1(0, 1, '0);
    step1(0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, storage words; power of two, >= 4.
REQ-003 SHALL have parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full level (1..DEPTH).
REQ-005 SHALL have parameter AE_THRESH, default 2, almost_empty level (0..DEPTH-1).
REQ-006 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-007 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  synchronous active-high reset.
REQ-009 SHALL have port din  input  WIDTH  write data.
REQ-010 SHALL have port wr_en  input  1  write request.
REQ-011 SHALL have port rd_en  input  1  read request (FWFT=1: acknowledge of head word).
REQ-012 SHALL have port dout  output  WIDTH  read data.
REQ-013 SHALL have port valid  output  1  dout holds newly read word.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current fill level.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL accept a write iff wr_en && !full: store din at wr_ptr, wr_ptr increments.
REQ-018 SHALL accept a read iff rd_en && !empty: rd_ptr increments.
REQ-019 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0.
REQ-020 SHALL update count as registered value: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 SHALL decode full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH) from registered count only.
REQ-022 SHALL evaluate full and empty in the request cycle; write at full or read at empty SHALL be rejected even if the other port is accepted that cycle.
REQ-023 SHALL leave pointers, count and memory unchanged for rejected requests.
REQ-024 SHALL make a written word readable the cycle after the write (empty deasserts one cycle after first write).
REQ-025 FWFT=0: SHALL register mem[rd_ptr] to dout on an accepted read and pulse valid high for exactly the following cycle; dout SHALL hold its last value otherwise.
REQ-026 FWFT=1: dout SHALL present mem[rd_ptr] whenever !empty; valid = !empty; accepted read advances to next word the following cycle.
REQ-027 SHALL set overflow on any cycle with wr_en && full, and underflow on any cycle with rd_en && empty; both SHALL stay set until rst.
REQ-028 SHALL preserve strict write order on read-back across any number of wraps.

Reset
REQ-029 SHALL, on a clock edge with rst=1, set wr_ptr, rd_ptr, count, dout, valid, overflow, underflow to 0, yielding empty=1, almost_empty=1, full=0, almost_full=0.
REQ-030 SHALL ignore wr_en and rd_en in any cycle with rst=1; memory contents need not be cleared.
REQ-031 SHALL discard all stored words on rst asserted mid-operation; next accepted write's word SHALL be the first read back.

Verification
REQ-032 Reset then idle -> count=0, empty=1, almost_empty=1, full=0, dout=0, valid=0, overflow=underflow=0.
REQ-033 FWFT=0, write 0..7 on consecutive cycles, then rd_en for 8 cycles -> valid one cycle after each rd_en, dout=0,1..7 in order, count back to 0.
REQ-034 Write 0..15 (DEPTH=16), then wr_en with din=0xDEAD -> full=1 at count 16, almost_full=1 from count 14, overflow=1, 0xDEAD never read; read-back yields 0..15.
REQ-035 rd_en while empty -> underflow=1, count stays 0, valid stays 0; overflow unaffected.
REQ-036 Preload 5 words, then wr_en=rd_en=1 for 40 cycles with incrementing din -> count stays 5, pointers wrap twice, output sequence continuous.
REQ-037 FWFT=1, write 0xA5 -> next cycle empty=0, valid=1, dout=0xA5 without rd_en; rd_en one cycle -> empty=1 next cycle; assert rst with 3 words stored -> count=0 next cycle.
